alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter nb_bits, default 32, SHALL set the operand width; sums are nb_bits+1 wide.
REQ-002 clock_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_i  in  1  reset, asynchronous and active-high.
REQ-004 req_valid_i  in  2  per-requester request valid, bit i = requester i.
REQ-005 req_ready_o  out  2  per-requester request accepted this cycle.
REQ-006 req_a_i  in  2*nb_bits  operand A, requester i at [i*nb_bits +: nb_bits].
REQ-007 req_b_i  in  2*nb_bits  operand B, same packing.
REQ-008 rsp_valid_o  out  2  per-requester result valid.
REQ-009 rsp_ready_i  in  2  per-requester result consumed.
REQ-010 rsp_sum_o  out  2*(nb_bits+1)  per-requester result, requester i at [i*(nb_bits+1) +: nb_bits+1].
REQ-011 alu_a_o  out  nb_bits  operand A to the shared registered adder.
REQ-012 alu_b_o  out  nb_bits  operand B to the shared registered adder.
REQ-013 alu_sum_i  in  nb_bits+1  registered sum from the shared adder, valid 2 cycles after operands are driven.
REQ-014 alu_resetb_o  out  1  active-low reset to the shared adder, SHALL equal ~reset_i combinationally.

Function
REQ-015 Each requester SHALL own a 3-state FSM: IDLE, INFLIGHT, DONE.
REQ-016 Requester i SHALL be eligible in a cycle iff state[i]==IDLE and req_valid_i[i]==1.
REQ-017 At most one requester SHALL be granted per cycle; req_ready_o[i]=1 only for the granted requester (combinational from eligibility and last_grant).
REQ-018 Arbitration SHALL be round-robin: if both eligible, grant the one not equal to last_grant; if one eligible, grant it; last_grant updates only on a grant.
REQ-019 A handshake (valid & ready) at edge E0 of cycle t SHALL move that requester IDLE->INFLIGHT.
REQ-020 In cycle t, alu_a_o/alu_b_o SHALL carry the granted requester's operands; with no grant both SHALL be 0.
REQ-021 A 2-stage tag pipeline (valid bit + requester id) SHALL track issues: stage1 loaded at E0, stage2 at E1.
REQ-022 When stage2 is valid in cycle t+2, alu_sum_i SHALL be captured into rsp_sum_o of the tagged requester at E2, state INFLIGHT->DONE, rsp_valid_o high from cycle t+3 (issue-to-response latency 3 cycles).
REQ-023 rsp_valid_o[i] and rsp_sum_o slice i SHALL hold stable while DONE and rsp_ready_i[i]==0.
REQ-024 rsp_valid_o[i] & rsp_ready_i[i] at an edge SHALL move DONE->IDLE and clear rsp_valid_o[i]; rsp_sum_o slice retains its value; the requester is eligible no earlier than the following cycle.
REQ-025 rsp_ready_i[i] while not DONE SHALL be ignored.
REQ-026 Issues from different requesters in consecutive cycles SHALL pipeline with no bubble; each requester has at most one outstanding operation.
REQ-027 Sum width: result is the full nb_bits+1 adder output, carry in MSB, passed unmodified.
REQ-028 Simultaneous capture for requester j and handshake for requester i SHALL both take effect in the same cycle.

Reset
REQ-029 reset_i high SHALL immediately force: all FSMs IDLE, tag pipeline invalid, rsp_valid_o=0, rsp_sum_o=0, last_grant=1 (requester 0 wins first contention), req_ready_o=0.
REQ-030 Reset mid-operation SHALL discard in-flight operations; no response is produced for them after reset release.

Verification
REQ-031 Single: req0 a=5,b=7 accepted at cycle 0, rsp_ready low -> rsp_valid_o[0]=1 from cycle 3, sum=12, held until rsp_ready_i[0].
REQ-032 Carry: a=0xFFFFFFFF,b=1 -> sum=0x1_0000_0000; a=b=0xFFFFFFFF -> 0x1_FFFFFFFE.
REQ-033 Contention: both valid from reset, rsp_ready=11 -> req0 granted cycle 0, req1 cycle 1, responses cycles 3 and 4, then alternation continues.
REQ-034 Backpressure: req0 DONE with rsp_ready_i[0]=0 for 10 cycles, req0 valid held -> req_ready_o[0]=0 throughout; req1 keeps being served.
REQ-035 Reset mid-flight: assert reset_i in cycle 1 after issue at cycle 0 -> all outputs 0 immediately, no rsp_valid after release, alu_resetb_o low during reset.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one registered adder.
// Each requester runs an IDLE/INFLIGHT/DONE FSM; a 2-stage tag pipeline routes sums back.
module alu_arbiter #(
  parameter int nb_bits = 32
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [2*nb_bits-1:0]       req_a_i,
  input  logic [2*nb_bits-1:0]       req_b_i,
  output logic [1:0]                 rsp_valid_o,
  input  logic [1:0]                 rsp_ready_i,
  output logic [2*(nb_bits+1)-1:0]   rsp_sum_o,
  output logic [nb_bits-1:0]         alu_a_o,
  output logic [nb_bits-1:0]         alu_b_o,
  input  logic [nb_bits:0]           alu_sum_i,
  output logic                       alu_resetb_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t state_q [2];
  state_t state_d [2];

  logic       last_grant_q;
  logic       s1_valid_q, s1_id_q;
  logic       s2_valid_q, s2_id_q;
  logic [1:0] eligible;
  logic [1:0] capture;
  logic       grant_valid;
  logic       grant_id;

  assign alu_resetb_o = ~reset_i;

  // Eligibility is masked by reset so req_ready_o drops the moment reset rises.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i]    = (state_q[i] == IDLE) & req_valid_i[i] & ~reset_i;
      capture[i]     = s2_valid_q & (s2_id_q == 1'(i));
      rsp_valid_o[i] = (state_q[i] == DONE);
    end
  end

  // NOTE: every output gets a default first, so no path can leave a latch behind.
  always_comb begin
    grant_valid = |eligible;
    grant_id    = (&eligible) ? ~last_grant_q : eligible[1];
    req_ready_o = 2'b00;
    alu_a_o     = '0;
    alu_b_o     = '0;
    if (grant_valid) begin
      req_ready_o = 2'b01 << grant_id;
      alu_a_o     = req_a_i[grant_id*nb_bits +: nb_bits];
      alu_b_o     = req_b_i[grant_id*nb_bits +: nb_bits];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE:     if (req_ready_o[i])  state_d[i] = INFLIGHT;
        INFLIGHT: if (capture[i])      state_d[i] = DONE;
        DONE:     if (rsp_ready_i[i])  state_d[i] = IDLE;
        default:                       state_d[i] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q[0]   <= IDLE;
      state_q[1]   <= IDLE;
      last_grant_q <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= 1'b0;
      rsp_sum_o    <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      if (grant_valid) last_grant_q <= grant_id;
      s1_valid_q <= grant_valid;
      s1_id_q    <= grant_id;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      // The adder output lines up with stage 2; the slice then holds until the next capture.
      for (int i = 0; i < 2; i++) begin
        if (capture[i]) rsp_sum_o[i*(nb_bits+1) +: nb_bits+1] <= alu_sum_i;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 2-stage registered adder.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_alu_arbiter;

  localparam int NB = 32;

  logic              clock_i;
  logic              reset_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [2*NB-1:0]   req_a_i;
  logic [2*NB-1:0]   req_b_i;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i;
  logic [2*NB+1:0]   rsp_sum_o;
  logic [NB-1:0]     alu_a_o;
  logic [NB-1:0]     alu_b_o;
  logic [NB:0]       alu_sum_i;
  logic              alu_resetb_o;

  logic [NB:0]       add_p1, add_p2;
  int                total  = 0;
  int                passed = 0;
  int                bp_grants;

  alu_arbiter #(.nb_bits(NB)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_sum_o    (rsp_sum_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_sum_i    (alu_sum_i),
    .alu_resetb_o (alu_resetb_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  // Shared adder: sum appears two cycles after the operands are presented.
  always_ff @(posedge clock_i or negedge alu_resetb_o) begin
    if (!alu_resetb_o) begin
      add_p1 <= '0;
      add_p2 <= '0;
    end else begin
      add_p1 <= {1'b0, alu_a_o} + {1'b0, alu_b_o};
      add_p2 <= add_p1;
    end
  end
  assign alu_sum_i = add_p2;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_i     = 1'b0;
    req_valid_i = 2'b00;
    rsp_ready_i = 2'b00;
    req_a_i     = '0;
    req_b_i     = '0;

    // Reset state, with both requesters already asking.
    #1 reset_i = 1'b1;
    req_valid_i = 2'b11;
    settle();
    check("rst_req_ready", 66'(req_ready_o), 66'(2'b00));
    check("rst_rsp_valid", 66'(rsp_valid_o), 66'(2'b00));
    check("rst_rsp_sum", 66'(rsp_sum_o), 66'd0);
    check("rst_alu_resetb", 66'(alu_resetb_o), 66'd0);
    check("rst_alu_a", 66'(alu_a_o), 66'd0);
    tick(); tick();

    // Single operation 5+7 on requester 0 with response backpressure.
    reset_i = 1'b0;
    req_valid_i = 2'b01;
    req_a_i = {32'd0, 32'd5};
    req_b_i = {32'd0, 32'd7};
    settle();
    check("s_c0_ready", 66'(req_ready_o), 66'(2'b01));
    check("s_c0_alu_a", 66'(alu_a_o), 66'd5);
    check("s_c0_alu_b", 66'(alu_b_o), 66'd7);
    check("s_alu_resetb", 66'(alu_resetb_o), 66'd1);
    tick(); req_valid_i = 2'b00; settle();
    check("s_c1_rsp_valid", 66'(rsp_valid_o), 66'(2'b00));
    check("s_c1_alu_a_idle", 66'(alu_a_o), 66'd0);
    tick(); settle();
    check("s_c2_rsp_valid", 66'(rsp_valid_o), 66'(2'b00));
    tick(); settle();
    check("s_c3_rsp_valid", 66'(rsp_valid_o), 66'(2'b01));
    check("s_c3_sum0", 66'(rsp_sum_o[32:0]), 66'd12);
    tick(); req_valid_i = 2'b01; settle();
    check("s_c4_hold_valid", 66'(rsp_valid_o), 66'(2'b01));
    check("s_c4_done_not_ready", 66'(req_ready_o), 66'(2'b00));
    tick(); req_valid_i = 2'b00; rsp_ready_i = 2'b10; settle();
    check("s_c5_hold_valid", 66'(rsp_valid_o), 66'(2'b01));
    check("s_c5_hold_sum0", 66'(rsp_sum_o[32:0]), 66'd12);
    tick(); rsp_ready_i = 2'b01; settle();
    check("s_c6_valid_before_hs", 66'(rsp_valid_o), 66'(2'b01));
    tick(); rsp_ready_i = 2'b00; settle();
    check("s_c7_valid_cleared", 66'(rsp_valid_o), 66'(2'b00));
    check("s_c7_sum0_retained", 66'(rsp_sum_o[32:0]), 66'd12);

    // Carry cases, both requesters; last grant was 0 so requester 1 wins first.
    tick();
    req_valid_i = 2'b11;
    req_a_i = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    req_b_i = {32'hFFFF_FFFF, 32'h0000_0001};
    settle();
    check("cy_c0_ready", 66'(req_ready_o), 66'(2'b10));
    check("cy_c0_alu_b", 66'(alu_b_o), 66'h0_FFFF_FFFF);
    tick(); settle();
    check("cy_c1_ready", 66'(req_ready_o), 66'(2'b01));
    check("cy_c1_alu_b", 66'(alu_b_o), 66'd1);
    tick(); settle();
    check("cy_c2_ready", 66'(req_ready_o), 66'(2'b00));
    tick(); settle();
    check("cy_c3_rsp_valid", 66'(rsp_valid_o), 66'(2'b10));
    check("cy_c3_sum1", 66'(rsp_sum_o[65:33]), 66'h1_FFFF_FFFE);
    tick(); settle();
    check("cy_c4_rsp_valid", 66'(rsp_valid_o), 66'(2'b11));
    check("cy_c4_sum0", 66'(rsp_sum_o[32:0]), 66'h1_0000_0000);
    tick(); req_valid_i = 2'b00; rsp_ready_i = 2'b11; settle();
    tick(); rsp_ready_i = 2'b00; settle();
    check("cy_drained", 66'(rsp_valid_o), 66'(2'b00));

    // Backpressure: requester 0 parked in DONE while requester 1 keeps cycling.
    tick();
    req_valid_i = 2'b01;
    req_a_i = {32'd10, 32'd3};
    req_b_i = {32'd20, 32'd4};
    settle();
    check("bp_issue0", 66'(req_ready_o), 66'(2'b01));
    tick(); req_valid_i = 2'b00;
    tick(); tick();
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b10;
    settle();
    check("bp_sum0", 66'(rsp_sum_o[32:0]), 66'd7);
    bp_grants = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        tick(); settle();
      end
      check("bp_req0_blocked", 66'(req_ready_o[0]), 66'd0);
      check("bp_req0_held", 66'(rsp_valid_o[0]), 66'd1);
      if (req_ready_o[1]) bp_grants++;
    end
    check("bp_req1_grants", 66'(bp_grants), 66'd3);
    check("bp_sum1", 66'(rsp_sum_o[65:33]), 66'd30);
    tick(); req_valid_i = 2'b00; rsp_ready_i = 2'b11;
    repeat (5) tick();

    // Reset while an operation is in flight.
    rsp_ready_i = 2'b00;
    req_valid_i = 2'b01;
    req_a_i = {32'd0, 32'd9};
    req_b_i = {32'd0, 32'd9};
    settle();
    check("mf_issue", 66'(req_ready_o), 66'(2'b01));
    tick(); req_valid_i = 2'b11; reset_i = 1'b1; settle();
    check("mf_rsp_valid", 66'(rsp_valid_o), 66'(2'b00));
    check("mf_rsp_sum", 66'(rsp_sum_o), 66'd0);
    check("mf_req_ready", 66'(req_ready_o), 66'(2'b00));
    check("mf_alu_resetb", 66'(alu_resetb_o), 66'd0);
    check("mf_alu_a", 66'(alu_a_o), 66'd0);
    tick(); tick();
    reset_i = 1'b0; req_valid_i = 2'b00; settle();
    for (int k = 0; k < 5; k++) begin
      check("mf_no_rsp", 66'(rsp_valid_o), 66'(2'b00));
      tick(); settle();
    end

    // Contention after reset: requester 0 wins first, then alternation.
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    req_a_i = {32'd100, 32'd1};
    req_b_i = {32'd200, 32'd2};
    settle();
    check("ct_c0_ready", 66'(req_ready_o), 66'(2'b01));
    check("ct_c0_alu_a", 66'(alu_a_o), 66'd1);
    tick(); settle();
    check("ct_c1_ready", 66'(req_ready_o), 66'(2'b10));
    check("ct_c1_alu_a", 66'(alu_a_o), 66'd100);
    tick(); settle();
    check("ct_c2_ready", 66'(req_ready_o), 66'(2'b00));
    tick(); settle();
    check("ct_c3_rsp_valid", 66'(rsp_valid_o), 66'(2'b01));
    check("ct_c3_sum0", 66'(rsp_sum_o[32:0]), 66'd3);
    tick(); settle();
    check("ct_c4_rsp_valid", 66'(rsp_valid_o), 66'(2'b10));
    check("ct_c4_sum1", 66'(rsp_sum_o[65:33]), 66'd300);
    check("ct_c4_ready", 66'(req_ready_o), 66'(2'b01));
    tick(); settle();
    check("ct_c5_ready", 66'(req_ready_o), 66'(2'b10));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
